// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width for WIDTH bits; never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder cell.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell walked LSB-first over WIDTH bits.
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | one bit per clock; completes when the counter reaches WIDTH-1
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = clog2_min1(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s, cell_c;
  logic             last_bit;

  fa_cell u_fa (
    .x(a_sh[0]),
    .y(b_sh[0]),
    .z(carry),
    .s(cell_s),
    .c(cell_c)
  );

  assign last_bit = (state == RUN) && (cnt == LAST);
  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign s_nxt    = (s_sh >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
  assign busy     = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= last_bit;
      if (state == IDLE) begin
        if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          s_sh  <= '0;
          carry <= cin;
          cnt   <= '0;
        end
      end else begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        s_sh  <= s_nxt;
        carry <= cell_c;
        cnt   <= cnt + CW'(1);
        if (last_bit) begin
          sum  <= s_nxt;
          cout <= cell_c;
        end
      end
    end
  end

endmodule
